softmax_stream: RTL and testbench

Parametrised, streaming softmax for the dense-layer output stage. Accepts `N_CLASS` signed logits serially and normalises them against the maximum logit, so no input can overflow the exponent. Emits fixed-point probabilities serially over a valid/ready handshake. Also reports the argmax class and a confidence flag, which the early-termination controller uses to stop inference once one class dominates.

---
 rtl/softmax_stream_pkg.sv | 9 +
 rtl/softmax_stream_seq_divider.sv | 51 +++++
 rtl/softmax_stream.sv | 126 ++++++++++++
 tb/tb_softmax_stream.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/softmax_stream_pkg.sv
// softmax_stream_pkg: shared widths and FSM encoding for the softmax output stage
package softmax_stream_pkg;
    localparam int DENSE_KSIZE = 10;
    localparam int BIT_DATA    = 8;
    localparam int BIT_SOFTMAX = 8;
    localparam int FRAC_BITS   = 12;
    localparam int CONF_THRESH = 230;
    typedef enum logic [1:0] {S_LOAD, S_SUM, S_DIV, S_OUT} state_t;
endpackage

// File: rtl/softmax_stream_seq_divider.sv
// seq_divider: restoring unsigned divider, one quotient bit per cycle, first bit in the start cycle
module seq_divider #(
    parameter int DIVIDEND_W = 21,
    parameter int DIVISOR_W  = 17,
    parameter int QUOT_W     = 9
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [QUOT_W-1:0]     quotient
);
    localparam int CNT_W = $clog2(QUOT_W + 1);
    logic                 busy_q, busy_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DIVISOR_W-1:0] rem_q, rem_d, rem_src;
    logic [QUOT_W-1:0]    lo_q, lo_d, lo_src;
    logic [DIVISOR_W:0]   trial, diff;
    logic                 ge, step;
    assign busy     = busy_q;
    assign done     = busy_q && cnt_q == CNT_W'(QUOT_W - 1);
    assign quotient = lo_q;
    always_comb begin
        step    = start | busy_q;
        rem_src = start ? DIVISOR_W'(dividend >> QUOT_W) : rem_q;
        lo_src  = start ? dividend[QUOT_W-1:0] : lo_q;
        trial   = {rem_src, lo_src[QUOT_W-1]};
        diff    = trial - {1'b0, divisor};
        ge      = trial >= {1'b0, divisor};
        rem_d   = step ? (ge ? DIVISOR_W'(diff) : DIVISOR_W'(trial)) : rem_q;
        lo_d    = step ? {lo_src[QUOT_W-2:0], ge} : lo_q;
        busy_d  = start | (busy_q & ~done);
        cnt_d   = start ? CNT_W'(1) : busy_q ? cnt_q + 1'b1 : cnt_q;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            rem_q  <= '0;
            lo_q   <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            rem_q  <= rem_d;
            lo_q   <= lo_d;
        end
    end
endmodule

// File: rtl/softmax_stream.sv
// softmax_stream: serial max-normalised softmax with argmax and confidence flag
module softmax_stream
    import softmax_stream_pkg::*;
#(
    parameter int N_CLASS = DENSE_KSIZE,
    parameter int DATA_W  = BIT_DATA,
    parameter int FRAC_W  = FRAC_BITS,
    parameter int OUT_W   = BIT_SOFTMAX,
    parameter int THRESH  = CONF_THRESH
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic signed [DATA_W-1:0]   x,
    input  logic                       x_valid,
    output logic                       x_ready,
    output logic [OUT_W-1:0]           y,
    output logic                       y_valid,
    input  logic                       y_ready,
    output logic [$clog2(N_CLASS)-1:0] y_index,
    output logic                       y_last,
    output logic [$clog2(N_CLASS)-1:0] argmax,
    output logic                       confident
);
    localparam int IDX_W  = $clog2(N_CLASS);
    localparam int E_W    = FRAC_W + 1;
    localparam int SUM_W  = FRAC_W + 1 + IDX_W;
    localparam int DVD_W  = E_W + OUT_W;
    localparam int Q_W    = OUT_W + 1;
    localparam int PROD_W = SUM_W + OUT_W + 1;
    localparam logic [E_W-1:0] ONE = E_W'(1) << FRAC_W;
    state_t                   state_q, state_d;
    logic [IDX_W-1:0]         cnt_q, cnt_d;
    logic signed [DATA_W-1:0] buf_q [N_CLASS];
    logic signed [DATA_W-1:0] max_q, max_d;
    logic [IDX_W-1:0]         argmax_q, argmax_d;
    logic [SUM_W-1:0]         sum_q, sum_d, sum_next;
    logic                     conf_q, conf_d;
    logic [DATA_W:0]          d;
    logic [E_W-1:0]           e;
    logic [Q_W-1:0]           quot;
    logic                     last_elem, x_fire, div_start, div_busy, div_done;
    assign x_ready   = state_q == S_LOAD;
    assign y_valid   = state_q == S_OUT;
    assign x_fire    = x_valid & x_ready;
    assign last_elem = cnt_q == IDX_W'(N_CLASS - 1);
    assign d         = {max_q[DATA_W-1], max_q} - {buf_q[cnt_q][DATA_W-1], buf_q[cnt_q]};
    assign e         = (d > (DATA_W+1)'(FRAC_W)) ? '0 : ONE >> d;
    assign sum_next  = sum_q + SUM_W'(e);
    assign div_start = state_q == S_DIV && !div_busy;
    assign y         = y_valid ? (quot[OUT_W] ? '1 : quot[OUT_W-1:0]) : '0;
    assign y_index   = cnt_q;
    assign y_last    = y_valid & last_elem;
    assign argmax    = argmax_q;
    assign confident = conf_q;
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        max_d    = max_q;
        argmax_d = argmax_q;
        sum_d    = sum_q;
        conf_d   = conf_q;
        case (state_q)
            S_LOAD: begin
                sum_d = '0;
                if (x_fire) begin
                    cnt_d   = last_elem ? '0 : cnt_q + 1'b1;
                    state_d = last_elem ? S_SUM : S_LOAD;
                    if (cnt_q == '0 || x > max_q) begin
                        max_d    = x;
                        argmax_d = cnt_q;
                    end
                end
            end
            S_SUM: begin
                sum_d   = sum_next;
                cnt_d   = last_elem ? '0 : cnt_q + 1'b1;
                state_d = last_elem ? S_DIV : S_SUM;
                if (last_elem)
                    conf_d = PROD_W'(THRESH) * PROD_W'(sum_next) <= (PROD_W'(1) << (FRAC_W + OUT_W));
            end
            S_DIV: state_d = div_done ? S_OUT : S_DIV;
            S_OUT: begin
                if (y_ready) begin
                    cnt_d   = last_elem ? '0 : cnt_q + 1'b1;
                    state_d = last_elem ? S_LOAD : S_DIV;
                end
            end
            default: state_d = S_LOAD;
        endcase
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_LOAD;
            cnt_q    <= '0;
            max_q    <= '0;
            argmax_q <= '0;
            sum_q    <= '0;
            conf_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            max_q    <= max_d;
            argmax_q <= argmax_d;
            sum_q    <= sum_d;
            conf_q   <= conf_d;
        end
    end
    always_ff @(posedge clock) begin
        if (x_fire)
            buf_q[cnt_q] <= x;
    end
    seq_divider #(
        .DIVIDEND_W(DVD_W),
        .DIVISOR_W (SUM_W),
        .QUOT_W    (Q_W)
    ) u_div (
        .clock    (clock),
        .reset    (reset),
        .start    (div_start),
        .dividend ({e, {OUT_W{1'b0}}}),
        .divisor  (sum_q),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (quot)
    );
endmodule

// File: tb/tb_softmax_stream.sv
// tb_softmax_stream: scoreboard bench for softmax_stream at default parameters
module tb_softmax_stream;
    localparam int N = 10;
    localparam int LAT = N + 8 + 1;
    localparam int GAP = 8 + 2;
    typedef struct {int y; int idx; int last; int am; int conf;} exp_t;
    logic              clock = 0;
    logic              reset;
    logic signed [7:0] x;
    logic              x_valid, x_ready;
    logic [7:0]        y;
    logic              y_valid, y_ready, y_last, confident;
    logic [3:0]        y_index, argmax;
    exp_t              sb [$];
    int                fr [N];
    int                checks = 0, errors = 0, cyc = 0;
    int                t_last = 0, last_xfer = 0;
    softmax_stream dut (
        .clock(clock), .reset(reset), .x(x), .x_valid(x_valid), .x_ready(x_ready),
        .y(y), .y_valid(y_valid), .y_ready(y_ready), .y_index(y_index), .y_last(y_last),
        .argmax(argmax), .confident(confident)
    );
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;
    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic expect_frame();
        int mx, am, s, conf, yv;
        int ee [N];
        mx = fr[0]; am = 0; s = 0;
        for (int k = 1; k < N; k++) if (fr[k] > mx) begin mx = fr[k]; am = k; end
        for (int k = 0; k < N; k++) begin
            ee[k] = (mx - fr[k] > 12) ? 0 : 4096 >> (mx - fr[k]);
            s += ee[k];
        end
        conf = (230 * s <= (1 << 20)) ? 1 : 0;
        for (int k = 0; k < N; k++) begin
            yv = ee[k] * 256 / s;
            if (yv > 255) yv = 255;
            sb.push_back('{yv, k, (k == N - 1) ? 1 : 0, am, conf});
        end
    endtask
    task automatic run_frame(input bit gaps);
        int n;
        expect_frame();
        for (int k = 0; k < N; k++) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin
                x_valid = 0; x = 8'($urandom);
                @(posedge clock); #1;
            end
            x = 8'(fr[k]); x_valid = 1; n = 0;
            while (!x_ready && n < 3000) begin @(posedge clock); #1; n++; end
            chk("x_ready_wait", int'(x_ready), 1);
            @(posedge clock); #1;
            if (k == N - 1) t_last = cyc;
        end
        x_valid = 0; x = 0;
    endtask
    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 3000) begin @(posedge clock); #1; n++; end
        chk("drain", sb.size(), 0);
    endtask
    task automatic wait_idx(input int idx);
        int n = 0;
        while (!(y_valid && y_index == 4'(idx)) && n < 3000) begin @(posedge clock); #1; n++; end
        chk("wait_idx", int'(y_index), idx);
    endtask
    always @(negedge clock) begin : monitor
        exp_t ex;
        static bit pv = 0, pr = 0;
        static int py = 0, pidx = 0;
        if (reset) pv = 0;
        else begin
            if (y_valid && !pv) begin
                if (y_index == 0) chk("latency", cyc - t_last, LAT);
                else chk("beat_gap", cyc - last_xfer, GAP);
            end
            if (y_valid && pv && !pr) begin
                chk("hold_y", int'(y), py);
                chk("hold_idx", int'(y_index), pidx);
            end
            if (y_valid) chk("x_ready_busy", int'(x_ready), 0);
            if (y_valid && y_ready) begin
                if (sb.size() == 0) chk("stale_beat", int'(y_index), -1);
                else begin
                    ex = sb.pop_front();
                    chk("y", int'(y), ex.y);
                    chk("y_index", int'(y_index), ex.idx);
                    chk("y_last", int'(y_last), ex.last);
                    chk("argmax", int'(argmax), ex.am);
                    chk("confident", int'(confident), ex.conf);
                end
                last_xfer = cyc;
            end
            pv = y_valid; pr = y_ready; py = int'(y); pidx = int'(y_index);
        end
    end
    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end
    initial begin
        reset = 1; x = 0; x_valid = 0; y_ready = 1;
        repeat (3) @(posedge clock);
        #1 reset = 0;
        chk("rst_x_ready", int'(x_ready), 1);
        chk("rst_y_valid", int'(y_valid), 0);
        chk("rst_y", int'(y), 0);
        chk("rst_y_index", int'(y_index), 0);
        chk("rst_y_last", int'(y_last), 0);
        chk("rst_argmax", int'(argmax), 0);
        chk("rst_confident", int'(confident), 0);
        for (int k = 0; k < N; k++) fr[k] = 5;
        run_frame(0); drain();
        for (int k = 0; k < N; k++) fr[k] = (k == 0) ? 20 : 0;
        run_frame(0); drain();
        for (int k = 0; k < N; k++) fr[k] = (k == 0) ? 1 : (k == 1) ? 0 : -100;
        run_frame(0); drain();
        for (int k = 0; k < N; k++) fr[k] = (k == 3 || k == 7) ? 5 : -128;
        run_frame(0); drain();
        for (int k = 0; k < N; k++) fr[k] = (k == 0) ? 1 : (k == 1) ? 0 : (k == 2) ? 1 : -3;
        run_frame(0);
        wait_idx(2);
        y_ready = 0;
        repeat (5) @(posedge clock);
        #1 y_ready = 1;
        drain();
        run_frame(1); drain();
        repeat (4) begin
            for (int k = 0; k < N; k++) fr[k] = int'($urandom_range(0, 255)) - 128;
            run_frame(1); drain();
        end
        for (int k = 0; k < N; k++) fr[k] = int'($urandom_range(0, 12)) - 6;
        run_frame(0);
        wait_idx(3);
        @(posedge clock); #1;
        reset = 1;
        @(posedge clock); #1;
        reset = 0;
        sb.delete();
        chk("midrst_y_valid", int'(y_valid), 0);
        chk("midrst_x_ready", int'(x_ready), 1);
        chk("midrst_y_index", int'(y_index), 0);
        repeat (30) @(posedge clock);
        #1;
        for (int k = 0; k < N; k++) fr[k] = (k == 3 || k == 7) ? 5 : -128;
        run_frame(0); drain();
        for (int k = 0; k < N; k++) fr[k] = (k == 0) ? 1 : (k == 1) ? 0 : -100;
        run_frame(1); drain();
        repeat (5) @(posedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
